// File: rtl/mux_logic_pkg.sv
// Shared op codes, FSM encoding and channel wrap helper for the mux_logic_seq datapath.
package mux_logic_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  // Successor channel with wrap-around; out-of-range inputs map to channel 0.
  function automatic int unsigned next_ch(input int unsigned s, input int unsigned num_ch);
    return (s + 1 >= num_ch) ? 0 : s + 1;
  endfunction

endpackage

// File: rtl/mux_logic_seq_if.sv
// Request/result bundle for mux_logic_seq. Optional out_par present with MUX_LOGIC_PARITY_EN.
interface mux_logic_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 8
) ();
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [SEL_W-1:0]        sel;
  logic [2:0]              op;
  logic                    scan_en;
  logic                    in_valid;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_err;
`ifdef MUX_LOGIC_PARITY_EN
  logic                    out_par;
`endif

  modport master (
`ifdef MUX_LOGIC_PARITY_EN
    input  out_par,
`endif
    output ch_data, sel, op, scan_en, in_valid, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_err
  );

  modport slave (
`ifdef MUX_LOGIC_PARITY_EN
    output out_par,
`endif
    input  ch_data, sel, op, scan_en, in_valid, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_err
  );

endinterface

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic unit: one of eight two-operand ops over WIDTH bits.
module logic_op_unit
  import mux_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = '0;
    unique case (op)
      OP_PASS: res = a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOTA: res = ~a;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mux_logic_seq.sv
// Channel mux + logic op with a one-entry registered output and auto-scan mode.
// Optional registered parity output enabled by MUX_LOGIC_PARITY_EN.
module mux_logic_seq
  import mux_logic_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 8
) (
  input logic            clk,
  input logic            rst,
  mux_logic_seq_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);

  state_e           state_q, state_d;
  logic             scan_q;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] ch_q;
  logic             err_q;

  logic             in_ready, fire, scan_rise, sel_err;
  logic [SEL_W-1:0] scan_ch, cur_ch, nxt_ch;
  logic [WIDTH-1:0] op_a, op_b, op_res, res_d;

  // A freshly enabled scan starts at channel 0 even before the counter register clears.
  assign scan_rise = bus.scan_en & ~scan_q;
  assign scan_ch   = scan_rise ? '0 : cnt_q;
  assign cur_ch    = bus.scan_en ? scan_ch : bus.sel;
  assign nxt_ch    = SEL_W'(next_ch(32'(cur_ch), NUM_CH));
  assign sel_err   = ~bus.scan_en & (32'(bus.sel) >= NUM_CH);

  assign in_ready  = ~rst & ((state_q == ST_IDLE) | bus.out_ready);
  assign fire      = in_ready & (bus.scan_en | bus.in_valid);

  // Compare-based selection keeps every part-select inside ch_data.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == SEL_W'(k)) op_a = bus.ch_data[k*WIDTH +: WIDTH];
      if (nxt_ch == SEL_W'(k)) op_b = bus.ch_data[k*WIDTH +: WIDTH];
    end
  end

  logic_op_unit #(
    .WIDTH(WIDTH)
  ) u_op (
    .a  (op_a),
    .b  (op_b),
    .op (bus.op),
    .res(op_res)
  );

  assign res_d = sel_err ? '0 : op_res;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.scan_en) begin
      if (fire)           cnt_d = nxt_ch;
      else if (scan_rise) cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fire) state_d = ST_VALID;
      ST_VALID: begin
        if (fire)               state_d = ST_VALID;
        else if (bus.out_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (state_q == ST_VALID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
      ch_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      scan_q <= bus.scan_en;
      cnt_q  <= cnt_d;
      if (fire) begin
        data_q <= res_d;
        ch_q   <= cur_ch;
        err_q  <= sel_err;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.out_data = data_q;
  assign bus.out_ch   = ch_q;
  assign bus.out_err  = err_q;

`ifdef MUX_LOGIC_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (fire) begin
      par_q <= ^res_d;
    end
  end

  assign bus.out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_logic_seq.sv
// Self-checking bench for mux_logic_seq: directed tables, corner sequences, random vs model.
module tb_mux_logic_seq;

  typedef struct {
    logic [3:0] sel;
    logic [2:0] op;
    logic [7:0] exp_data;
    logic [3:0] exp_ch;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_logic_seq_if #(.WIDTH(8), .NUM_CH(8)) bus ();
  mux_logic_seq #(.WIDTH(8), .NUM_CH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  mux_logic_seq_if #(.WIDTH(8), .NUM_CH(6)) bus6 ();
  mux_logic_seq #(.WIDTH(8), .NUM_CH(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  logic [7:0] ch  [8];
  logic [7:0] ch6 [6];

  always_comb begin
    for (int k = 0; k < 8; k++) bus.ch_data[k*8 +: 8] = ch[k];
  end
  always_comb begin
    for (int k = 0; k < 6; k++) bus6.ch_data[k*8 +: 8] = ch6[k];
  end

  int tests = 0;
  int fails = 0;

  // Truth tables indexed by {a_bit, b_bit}, one per op code.
  logic [3:0] tt_tab [8] = '{4'b1100, 4'b1000, 4'b1110, 4'b0011,
                             4'b0111, 4'b0001, 4'b0110, 4'b1001};

  bit         m_valid;
  logic [7:0] m_data;
  logic [2:0] m_ch;
  int         m_cnt;
  bit         m_scan_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_logic(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    logic [7:0] r;
    logic [3:0] tt;
    tt = tt_tab[op];
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic model_reset();
    m_valid     = 1'b0;
    m_data      = '0;
    m_ch        = '0;
    m_cnt       = 0;
    m_scan_prev = 1'b0;
  endtask

  // One clock of the 8-channel DUT; inputs are already driven, called just after a negedge.
  task automatic cycle();
    bit         rdy, fire, scan, ordy;
    int         s;
    logic [7:0] nd;
    #1;
    ordy = bus.out_ready;
    scan = bus.scan_en;
    rdy  = !m_valid || ordy;
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    fire = rdy && (scan || bus.in_valid);
    s    = scan ? (m_scan_prev ? m_cnt : 0) : int'(bus.sel);
    nd   = ref_logic(ch[s], ch[(s + 1) % 8], bus.op);
    @(posedge clk);
    if (fire) begin
      m_valid = 1'b1;
      m_data  = nd;
      m_ch    = s[2:0];
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (scan) begin
      if (fire)              m_cnt = (s + 1) % 8;
      else if (!m_scan_prev) m_cnt = 0;
    end
    m_scan_prev = scan;
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_data", 32'(bus.out_data), 32'(m_data));
      check("out_ch", 32'(bus.out_ch), 32'(m_ch));
      check("out_err", 32'(bus.out_err), 32'd0);
`ifdef MUX_LOGIC_PARITY_EN
      check("out_par", 32'(bus.out_par), 32'(^m_data));
`endif
    end
    @(negedge clk);
  endtask

  vec_t       tab  [10];
  vec_t       tab6 [4];
  logic [7:0] held;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.sel = '0; bus.op = '0; bus.scan_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus6.sel = '0; bus6.op = '0; bus6.scan_en = 1'b0; bus6.in_valid = 1'b0;
    bus6.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) ch[k] = 8'(k * 17 + 1);
    for (int k = 0; k < 6; k++) ch6[k] = 8'(8'hA0 + k);
    model_reset();

    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All ops on channel 2/3, then wrap-around on channel 7/0.
    ch[2] = 8'hF0; ch[3] = 8'h3C; ch[7] = 8'hAA; ch[0] = 8'h55;
    tab[0] = '{4'd2, 3'b000, 8'hF0, 4'd2, 1'b0};
    tab[1] = '{4'd2, 3'b001, 8'h30, 4'd2, 1'b0};
    tab[2] = '{4'd2, 3'b010, 8'hFC, 4'd2, 1'b0};
    tab[3] = '{4'd2, 3'b011, 8'h0F, 4'd2, 1'b0};
    tab[4] = '{4'd2, 3'b100, 8'hCF, 4'd2, 1'b0};
    tab[5] = '{4'd2, 3'b101, 8'h03, 4'd2, 1'b0};
    tab[6] = '{4'd2, 3'b110, 8'hCC, 4'd2, 1'b0};
    tab[7] = '{4'd2, 3'b111, 8'h33, 4'd2, 1'b0};
    tab[8] = '{4'd7, 3'b001, 8'h00, 4'd7, 1'b0};
    tab[9] = '{4'd7, 3'b010, 8'hFF, 4'd7, 1'b0};
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.sel = tab[i].sel[2:0];
      bus.op  = tab[i].op;
      cycle();
      check("tab_data", 32'(bus.out_data), 32'(tab[i].exp_data));
      check("tab_ch", 32'(bus.out_ch), 32'(tab[i].exp_ch));
    end
    bus.in_valid = 1'b0;
    cycle();

    // Backpressure: result held for three stalled cycles, then next request taken at once.
    bus.sel = 3'd1; bus.op = 3'b110; bus.in_valid = 1'b1;
    cycle();
    held = ch[1] ^ ch[2];
    bus.out_ready = 1'b0; bus.sel = 3'd4; bus.op = 3'b010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold", 32'(bus.out_data), 32'(held));
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_next_data", 32'(bus.out_data), 32'(ch[4] | ch[5]));
    check("bp_next_ch", 32'(bus.out_ch), 32'd4);
    bus.in_valid = 1'b0;
    cycle();
    check("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while a result is held.
    bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.sel = 3'd3; bus.op = 3'b000;
    cycle();
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'd0);
    check("arst_out_ch", 32'(bus.out_ch), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cycle();

    // Scan walk with wrap, then a two-cycle stall that must freeze the counter.
    for (int k = 0; k < 8; k++) ch[k] = 8'(8'h10 + k);
    bus.op = 3'b000; bus.scan_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("scan_ch", 32'(bus.out_ch), 32'(i % 8));
      check("scan_data", 32'(bus.out_data), 32'(8'h10 + i % 8));
    end
    bus.out_ready = 1'b0;
    cycle();
    cycle();
    check("scan_stall_ch", 32'(bus.out_ch), 32'd1);
    bus.out_ready = 1'b1;
    cycle();
    check("scan_resume_ch", 32'(bus.out_ch), 32'd2);
    check("scan_resume_data", 32'(bus.out_data), 32'h12);
    bus.scan_en = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) bus.scan_en = ~bus.scan_en;
      if ($urandom_range(0, 7) == 0) ch[$urandom_range(0, 7)] = 8'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.sel       = 3'($urandom);
      bus.op        = 3'($urandom);
      cycle();
    end
    bus.scan_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // Six-channel instance: out-of-range selects and wrap from channel 5 to 0.
    tab6[0] = '{4'd6, 3'b000, 8'h00, 4'd6, 1'b1};
    tab6[1] = '{4'd5, 3'b000, 8'hA5, 4'd5, 1'b0};
    tab6[2] = '{4'd7, 3'b110, 8'h00, 4'd7, 1'b1};
    tab6[3] = '{4'd5, 3'b001, 8'hA0, 4'd5, 1'b0};
    bus6.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus6.sel = tab6[i].sel[2:0];
      bus6.op  = tab6[i].op;
      @(posedge clk);
      #1;
      check("oor_valid", 32'(bus6.out_valid), 32'd1);
      check("oor_err", 32'(bus6.out_err), 32'(tab6[i].exp_err));
      check("oor_data", 32'(bus6.out_data), 32'(tab6[i].exp_data));
      check("oor_ch", 32'(bus6.out_ch), 32'(tab6[i].exp_ch));
      @(negedge clk);
    end
    bus6.in_valid = 1'b0; bus6.op = 3'b000; bus6.scan_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      check("scan6_ch", 32'(bus6.out_ch), 32'(i % 6));
      check("scan6_data", 32'(bus6.out_data), 32'(8'hA0 + i % 6));
      @(negedge clk);
    end
    bus6.scan_en = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_logic_seq.md
Name: mux_logic_seq

Overview:
- Parametrised successor to the team's 8:1 bit mux and A/B logic block.
- Selects operand A from NUM_CH channels, each WIDTH bits wide. Operand B is the next channel up, with wrap-around.
- Applies one of eight bitwise logic ops and registers the result behind a valid/ready handshake.
- Adds an auto-scan mode: an internal counter walks all channels and emits one result per channel. Used as the datapath front end for the board's switch/LED test designs.

Parameters:
- WIDTH, 8, bits per channel and per result
- NUM_CH, 8, number of input channels (2..16, any value, not only powers of 2)
- SEL_W, $clog2(NUM_CH), select/counter width (localparam, not overridable)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ch_data  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  channel select, manual mode only
- op  in  3  logic op code
- scan_en  in  1  1 = auto-scan mode, 0 = manual mode
- in_valid  in  1  request valid (manual mode)
- in_ready  out  1  request accepted this cycle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  registered result
- out_ch  out  SEL_W  channel index that produced out_data
- out_err  out  1  sel was out of range (sel >= NUM_CH)

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, out_err=0, scan counter=0, FSM=IDLE. in_ready=0 while rst asserted.
- Operands: A = ch[s]; B = ch[(s+1) mod NUM_CH], so channel NUM_CH-1 pairs with channel 0.
- Op codes:
  - 000 PASS A
  - 001 A&B
  - 010 A|B
  - 011 ~A
  - 100 ~(A&B)
  - 101 ~(A|B)
  - 110 A^B
  - 111 ~(A^B)
- All ops are bitwise over WIDTH bits.
- in_ready = !out_valid || out_ready (one-entry output register with pass-through on drain).
- Accept: a transfer occurs when fire = (manual: in_valid && in_ready; scan: in_ready).
- Latency: result appears on out_* the cycle after fire. Full throughput, 1 result per clock with out_ready held high.
- Output stability: out_data/out_ch/out_err stay stable while out_valid && !out_ready.
- Out-of-range sel in manual mode: out_data=0, out_err=1, out_ch=sel truncated to SEL_W. Operands are never indexed outside ch_data.
- FSM states:
  - IDLE: out_valid=0. Goes to VALID on fire.
  - VALID: out_valid=1. out_ready without a new fire goes to IDLE; fire returns to VALID.
- Scan counter:
  - Advances only on fire in scan mode; wraps NUM_CH-1 -> 0.
  - op is sampled on each fire.
  - Counter holds its value when scan_en drops.
  - Counter resets to 0 on the rising edge of scan_en.
- Mode switch: a scan_en change while VALID and stalled does not alter the held result.
- in_valid is ignored in scan mode; sel is ignored in scan mode.
- Reset mid-transfer: the result is discarded and all outputs go to reset values immediately.

Optional Feature:
- Macro: MUX_LOGIC_PARITY_EN.
- Defined: extra output port out_par (1 bit) = ^out_data, registered alongside out_data, reset 0, same hold rules.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_logic_pkg holds:
  - op code localparams (OP_PASS..OP_XNOR)
  - FSM state encoding (ST_IDLE, ST_VALID)
  - function next_ch(s, NUM_CH) for the wrap-around
- One sub-module, logic_op_unit: purely combinational; WIDTH-parametrised; takes A, B, op and returns the result.
- Mux, counter, FSM and output register live in mux_logic_seq.

Test Plan:
- Reset: rst=1 mid-run with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 asynchronously, before the next clk edge.
- Manual, all ops: NUM_CH=8, WIDTH=8, ch2=8'hF0, ch3=8'h3C, sel=2, each op 000..111, out_ready=1 -> out_data = F0, 30, FC, 0F, CF, 03, CC, 33 in turn, one cycle after each accept; out_ch=2.
- Wrap-around: sel=7, ch7=8'hAA, ch0=8'h55, op=001 (AND) -> out_data=8'h00, out_ch=7; op=010 (OR) -> 8'hFF.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data held; out_ready=1 -> the next request is accepted the same cycle, with no lost or duplicated result.
- Scan: scan_en=1, op=000, channels k=8'h10+k, out_ready=1 -> out_ch sequence 0..7,0,1 with out_data 10..17,10,11; holding out_ready=0 for 2 cycles freezes the counter.
- Out-of-range: NUM_CH=6 (SEL_W=3), sel=6 -> out_err=1, out_data=0; sel=5, op=000 -> out_err=0, out_data=ch5.
